// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and flag struct for the KGP-RISC ALU datapath.
// Struct members are ordered so that bit positions match the FLAG_* indices.
package alu_pkg;
   localparam int GRP_W  = 4;
   localparam int FLAG_C = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 2;
   localparam int FLAG_S = 3;
   typedef struct packed {
      logic sign;
      logic zero;
      logic overflow;
      logic carry;
   } add_flags_t;
endpackage

// File: rtl/lookahead_carry_unit.sv
// lookahead_carry_unit: second-level carry lookahead over group P/G, flattened within
// each block of four groups; blocks chain through their block carry-in.
module lookahead_carry_unit
   import alu_pkg::*;
#(
   parameter int NGRP = 8
) (
   input  logic [NGRP-1:0] p_i,
   input  logic [NGRP-1:0] g_i,
   input  logic            cin_i,
   output logic [NGRP:0]   c_o
);
   logic [NGRP:0] c;
   always_comb begin
      c    = '0;
      c[0] = cin_i;
      for (int k = 0; k < NGRP; k++) begin
         logic pp;
         pp = 1'b1;
         for (int j = k; j >= (k / GRP_W) * GRP_W; j--) begin
            c[k+1] = c[k+1] | (pp & g_i[j]);
            pp     = pp & p_i[j];
         end
         c[k+1] = c[k+1] | (pp & c[(k / GRP_W) * GRP_W]);
      end
   end
   assign c_o = c;
endmodule

// File: rtl/cla_add32_pipe.sv
// cla_add32_pipe: two-stage pipelined carry-lookahead add/subtract with valid/ready.
// Stage 1 registers per-bit and per-group P/G; stage 2 resolves carries into the output regs.
module cla_add32_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             sign
);
   localparam int NGRP = WIDTH / GRP_W;
   logic             s1_valid_q, cin_q, a_msb_q, b_msb_q, out_valid_q, s1_adv, s2_adv;
   logic [WIDTH-1:0] bx, p_d, g_d, p_q, g_q, bc, sum_d, sum_q;
   logic [NGRP-1:0]  gp_d, gg_d, gp_q, gg_q;
   logic [NGRP:0]    gc;
   add_flags_t       flags_d, flags_q;
   assign s2_adv   = !out_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;
   always_comb begin
      bx   = b ^ {WIDTH{op_sub}};
      p_d  = a ^ bx;
      g_d  = a & bx;
      gp_d = '0;
      gg_d = '0;
      for (int k = 0; k < NGRP; k++) begin
         logic [GRP_W-1:0] pk, gk;
         pk      = p_d[k*GRP_W +: GRP_W];
         gk      = g_d[k*GRP_W +: GRP_W];
         gp_d[k] = &pk;
         gg_d[k] = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1]) | (pk[3] & pk[2] & pk[1] & gk[0]);
      end
   end
   lookahead_carry_unit #(.NGRP(NGRP)) u_lcu (
      .p_i   (gp_q),
      .g_i   (gg_q),
      .cin_i (cin_q),
      .c_o   (gc)
   );
   // Ripple inside each 4-bit group from the lookahead group carry-in.
   always_comb begin
      bc = '0;
      for (int k = 0; k < NGRP; k++) begin
         logic c;
         c = gc[k];
         for (int j = 0; j < GRP_W; j++) begin
            bc[k*GRP_W+j] = c;
            c = g_q[k*GRP_W+j] | (p_q[k*GRP_W+j] & c);
         end
      end
      sum_d            = p_q ^ bc;
      flags_d.carry    = gc[NGRP];
      flags_d.overflow = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
      flags_d.zero     = sum_d == '0;
      flags_d.sign     = sum_d[WIDTH-1];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         cin_q       <= 1'b0;
         a_msb_q     <= 1'b0;
         b_msb_q     <= 1'b0;
         p_q         <= '0;
         g_q         <= '0;
         gp_q        <= '0;
         gg_q        <= '0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         flags_q     <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= in_valid;
            cin_q      <= op_sub;
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= bx[WIDTH-1];
            p_q        <= p_d;
            g_q        <= g_d;
            gp_q       <= gp_d;
            gg_q       <= gg_d;
         end
         if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            sum_q       <= sum_d;
            flags_q     <= flags_d;
         end
      end
   end
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign carry     = flags_q[FLAG_C];
   assign overflow  = flags_q[FLAG_V];
   assign zero      = flags_q[FLAG_Z];
   assign sign      = flags_q[FLAG_S];
endmodule

// File: tb/tb_cla_add32_pipe.sv
// tb_cla_add32_pipe: directed vectors against literals plus an arithmetic reference model
// checked on every output transfer, with back-pressure and mid-flight reset.
module tb_cla_add32_pipe;
   logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b1;
   logic        in_ready, out_valid, carry, overflow, zero, sign;
   logic [31:0] a = '0, b = '0, sum;
   int          n_cmp = 0, n_bad = 0, delivered = 0, base;
   logic [35:0] exp_q[$];
   logic        prev_stall = 1'b0;
   logic [31:0] prev_sum = '0;
   logic [31:0] va [8] = '{32'h0000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'h7FFF_FFFF,
                           32'h0000_000F, 32'hFFFF_FFFF, 32'h1234_5678, 32'hAAAA_AAAA};
   logic [31:0] vb [8] = '{32'h0000_0000, 32'h2152_4111, 32'h8000_0000, 32'h8000_0000,
                           32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h5555_5555};
   logic        vs [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;

   cla_add32_pipe dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry(carry), .overflow(overflow), .zero(zero), .sign(sign)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // {carry, overflow, zero, sign, sum} from plain integer arithmetic.
   function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
      longint      r;
      logic [32:0] u;
      logic        c;
      r = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
      u = s ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
      c = s ? (x >= y) : u[32];
      return {c, r != longint'($signed(u[31:0])), u[31:0] == 32'h0, u[31], u[31:0]};
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_out_valid", 64'(out_valid), 64'd1);
               chk("stall_sum", 64'(sum), 64'(prev_sum));
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) chk("spurious_output", 64'(out_valid), 64'd0);
               else begin
                  chk("model_result", 64'({carry, overflow, zero, sign, sum}), 64'(exp_q.pop_front()));
                  delivered++;
               end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, op_sub));
         end
      end
   end

   task automatic dir(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input logic [35:0] e, input string nm);
      @(posedge clk); #1;
      a = x; b = y; op_sub = s; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_early_valid"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({nm, "_out_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_result"}, 64'({carry, overflow, zero, sign, sum}), 64'(e));
   endtask

   task automatic send(input logic [31:0] x, input logic [31:0] y, input logic s);
      bit acc = 1'b0;
      a = x; b = y; op_sub = s; in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 64'(in_ready), 64'd1);
   endtask

   task automatic drain(input int n, input string nm);
      for (int i = 0; i < 40 && delivered != n; i++) @(posedge clk);
      chk(nm, 64'(delivered), 64'(n));
   endtask

   initial begin
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_fields", 64'({carry, overflow, zero, sign, sum}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #3;
      rst = 1'b0;

      dir(32'h0000_0005, 32'h0000_0003, 1'b0, {4'b0000, 32'h0000_0008}, "add_5_3");
      dir(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {4'b1010, 32'h0000_0000}, "ripple");
      dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {4'b0101, 32'h8000_0000}, "ovf_add");
      dir(32'h8000_0000, 32'h0000_0001, 1'b1, {4'b1100, 32'h7FFF_FFFF}, "ovf_sub");
      dir(32'h0000_0003, 32'h0000_0005, 1'b1, {4'b0001, 32'hFFFF_FFFE}, "borrow");
      dir(32'h0000_0005, 32'h0000_0005, 1'b1, {4'b1010, 32'h0000_0000}, "sub_eq");

      @(posedge clk); #1;
      out_ready = 1'b0;
      base = delivered;
      send(32'h0000_0001, 32'h0000_0002, 1'b0);
      send(32'hFFFF_0000, 32'h0001_0000, 1'b0);
      a = 32'h0000_0010; b = 32'h0000_0020; op_sub = 1'b1; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready_full", 64'(in_ready), 64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(32'h0000_0010, 32'h0000_0020, 1'b1);
      send(32'h8000_0001, 32'h8000_0001, 1'b0);
      drain(base + 4, "bp_delivered");

      @(posedge clk); #1;
      base = delivered;
      fork
         begin
            repeat (30) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
         begin
            for (int i = 0; i < 8; i++) send(va[i], vb[i], vs[i]);
         end
      join
      out_ready = 1'b1;
      drain(base + 8, "stream_delivered");

      @(posedge clk); #1;
      a = 32'd10; b = 32'd20; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 32'd7; b = 32'd2; op_sub = 1'b1;
      @(posedge clk); #3;
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_fields", 64'({carry, overflow, zero, sign, sum}), 64'd0);
      @(posedge clk); #3;
      rst = 1'b0;
      dir(32'h1234_5678, 32'h1111_1111, 1'b0, {4'b0000, 32'h2345_6789}, "after_rst");
      @(posedge clk); #1;
      chk("model_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
